// File: rtl/tlc_pkg.sv
// Shared lamp codes and phase-state encoding for the
// intersection light controller.
package tlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } tlc_state_e;

  function automatic logic [2:0] lamp_of(
    input tlc_state_e s
  );
    unique case (s)
      ST_GREEN:  return LAMP_GRN;
      ST_YELLOW: return LAMP_YEL;
      default:   return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin picker: first set pend bit
// scanning base+1, base+2, ... (base itself last).
module tlc_rr_pick #(
  parameter int NUM_PH = 4,
  parameter int PW     = $clog2(NUM_PH)
) (
  input  logic [NUM_PH-1:0] i_pend,
  input  logic [PW-1:0]     i_base,
  output logic              o_valid,
  output logic [PW-1:0]     o_idx
);

  logic [PW-1:0] w_pos;

  // descending scan so the nearest hit wins
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = NUM_PH; k >= 1; k--) begin
      w_pos = PW'((int'(i_base) + k) % NUM_PH);
      if (i_pend[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven round-robin phase scheduler with
// min/max green, yellow, all-red and preemption.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int NUM_PH    = 4,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YEL_T     = 2,
  parameter int ALLRED_T  = 1,
  parameter int CW        = 5,
  parameter int PW        = $clog2(NUM_PH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PH-1:0]     req,
  input  logic                  preempt,
  input  logic [PW-1:0]         preempt_ph,
  output logic [3*NUM_PH-1:0]   light,
  output logic [PW-1:0]         active_ph,
  output logic [NUM_PH-1:0]     req_pend,
  output logic                  phase_done
);

  localparam logic [CW-1:0] T_GMIN = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] T_GMAX = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] T_YEL  = CW'(YEL_T - 1);
  localparam logic [CW-1:0] T_AR   = CW'(ALLRED_T - 1);
  localparam logic [PW:0]   PH_LIM = (PW+1)'(NUM_PH);
  localparam logic [3*NUM_PH-1:0] L_RST =
    {{(NUM_PH-1){LAMP_RED}}, LAMP_GRN};

  tlc_state_e           r_state, w_state_nx;
  logic [CW-1:0]        r_timer, w_timer_nx, w_tinc;
  logic [PW-1:0]        r_ph, w_ph_nx, w_pick_ph;
  logic [NUM_PH-1:0]    r_pend, w_pend_nx;
  logic [NUM_PH-1:0]    w_act_oh, w_new_oh, w_set;
  logic [3*NUM_PH-1:0]  r_light, w_light_nx;
  logic                 r_done, w_done_nx, w_enter;
  logic                 w_pick_v, w_pre_ok, w_any, w_exit;

  tlc_rr_pick #(
    .NUM_PH (NUM_PH),
    .PW     (PW)
  ) u_pick (
    .i_pend  (r_pend),
    .i_base  (r_ph),
    .o_valid (w_pick_v),
    .o_idx   (w_pick_ph)
  );

  assign w_tinc   = r_timer + CW'(1);
  assign w_pre_ok = preempt && ({1'b0, preempt_ph} < PH_LIM);
  assign w_any    = |r_pend;
  assign w_exit   = (r_timer >= T_GMIN) && w_any &&
                    (!req[r_ph] || r_timer == T_GMAX);

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_ph_nx    = r_ph;
    w_done_nx  = 1'b0;
    w_enter    = 1'b0;
    unique case (r_state)
      ST_GREEN: begin
        if (w_pre_ok && preempt_ph != r_ph) begin
          w_state_nx = ST_YELLOW;
          w_timer_nx = '0;
        end else if (w_pre_ok) begin
          if (r_timer < T_GMIN) w_timer_nx = w_tinc;
        end else if (w_exit) begin
          w_state_nx = ST_YELLOW;
          w_timer_nx = '0;
        end else if (r_timer < T_GMIN ||
                     (w_any && r_timer < T_GMAX)) begin
          w_timer_nx = w_tinc;
        end
      end
      ST_YELLOW: begin
        if (r_timer == T_YEL) begin
          w_state_nx = ST_ALLRED;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = w_tinc;
        end
      end
      ST_ALLRED: begin
        if (r_timer == T_AR) begin
          w_state_nx = ST_GREEN;
          w_timer_nx = '0;
          w_done_nx  = 1'b1;
          w_enter    = 1'b1;
          if (w_pre_ok)      w_ph_nx = preempt_ph;
          else if (w_pick_v) w_ph_nx = w_pick_ph;
          else               w_ph_nx = '0;
        end else begin
          w_timer_nx = w_tinc;
        end
      end
      default: begin
        w_state_nx = ST_GREEN;
        w_timer_nx = '0;
      end
    endcase
  end

  // green phase has its own demand served; new green clears wins
  assign w_act_oh  = NUM_PH'(1) << r_ph;
  assign w_new_oh  = NUM_PH'(1) << w_ph_nx;
  assign w_set     = req & ~((r_state == ST_GREEN) ? w_act_oh : '0);
  assign w_pend_nx = (r_pend | w_set) & ~(w_enter ? w_new_oh : '0);

  always_comb begin
    w_light_nx = {NUM_PH{LAMP_RED}};
    for (int i = 0; i < NUM_PH; i++) begin
      if (PW'(i) == w_ph_nx)
        w_light_nx[3*i +: 3] = lamp_of(w_state_nx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_GREEN;
      r_timer <= '0;
      r_ph    <= '0;
      r_pend  <= '0;
      r_done  <= 1'b0;
      r_light <= L_RST;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_ph    <= w_ph_nx;
      r_pend  <= w_pend_nx;
      r_done  <= w_done_nx;
      r_light <= w_light_nx;
    end
  end

  assign light      = r_light;
  assign active_ph  = r_ph;
  assign req_pend   = r_pend;
  assign phase_done = r_done;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: directed vector tables,
// hand sequences and a random run against a timing model.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  localparam int NPH  = 4;
  localparam int GMIN = 5;
  localparam int GMAX = 15;
  localparam int YEL  = 2;
  localparam int AR   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        preempt;
  logic [1:0]  preempt_ph;
  logic [11:0] light;
  logic [1:0]  active_ph;
  logic [3:0]  req_pend;
  logic        phase_done;

  tlc_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .preempt    (preempt),
    .preempt_ph (preempt_ph),
    .light      (light),
    .active_ph  (active_ph),
    .req_pend   (req_pend),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         pre;
    logic [1:0] pph;
    int         eph;
    logic [2:0] elamp;
    logic [3:0] epend;
    bit         edone;
  } vec_t;

  vec_t tv[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_light(input int ph,
                                            input logic [2:0] lamp);
    logic [11:0] l;
    l = {4{LAMP_RED}};
    l[3*ph +: 3] = lamp;
    return l;
  endfunction

  task automatic add(input bit r, input logic [3:0] rq,
                     input bit p, input logic [1:0] pp,
                     input int eph, input logic [2:0] el,
                     input logic [3:0] epd, input bit ed);
    tv.push_back('{r, rq, p, pp, eph, el, epd, ed});
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst = tv[i].rst; req = tv[i].req;
      preempt = tv[i].pre; preempt_ph = tv[i].pph;
      tick();
      check($sformatf("row%0d_light", i), 32'(light),
            32'(exp_light(tv[i].eph, tv[i].elamp)));
      check($sformatf("row%0d_ph", i), 32'(active_ph),
            32'(tv[i].eph));
      check($sformatf("row%0d_pend", i), 32'(req_pend),
            32'(tv[i].epend));
      check($sformatf("row%0d_done", i), 32'(phase_done),
            32'(tv[i].edone));
    end
    rst = 1'b0; req = '0; preempt = 1'b0; preempt_ph = '0;
  endtask

  task automatic wait_done(input string nm, input int bound,
                           input int eph);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (phase_done !== 1'b1 && c < bound);
    check(nm, {29'd0, phase_done, active_ph}, {29'd0, 1'b1, 2'(eph)});
  endtask

  // never more than one group showing a non-red lamp
  always @(negedge clk) begin
    int nr;
    if (mon_en) begin
      nr = 0;
      for (int g = 0; g < NPH; g++)
        if (light[3*g +: 3] !== LAMP_RED) nr++;
      n_chk++;
      if (nr > 1) begin
        n_fail++;
        $display("FAIL one_green: %0d non-red groups light=%h, need <=1",
                 nr, light);
      end
    end
  end

  // reference model: 0=green 1=yellow 2=all-red, cnt=cycles in stage
  int         m_ph, m_st, m_cnt;
  logic [3:0] m_pend;
  bit         m_done;

  function automatic logic [2:0] st_lamp(input int st);
    if (st == 0) return LAMP_GRN;
    if (st == 1) return LAMP_YEL;
    return LAMP_RED;
  endfunction

  task automatic model_step(input bit r, input logic [3:0] rq,
                            input bit pre, input logic [1:0] pph);
    logic [3:0] np;
    bit others;
    int lim, nx;
    if (r) begin
      m_ph = 0; m_st = 0; m_cnt = 0; m_pend = '0; m_done = 0;
      return;
    end
    np = m_pend | rq;
    if (m_st == 0) np[m_ph] = 1'b0;
    m_done = 0;
    if (m_st == 0) begin
      others = (m_pend != 0);
      if (pre && int'(pph) != m_ph) begin
        m_st = 1; m_cnt = 0;
      end else if (pre) begin
        if (m_cnt < GMIN - 1) m_cnt++;
      end else if (others && m_cnt >= GMIN - 1 &&
                   (!rq[m_ph] || m_cnt >= GMAX - 1)) begin
        m_st = 1; m_cnt = 0;
      end else begin
        lim = others ? GMAX - 1 : GMIN - 1;
        if (m_cnt < lim) m_cnt++;
      end
    end else if (m_st == 1) begin
      m_cnt++;
      if (m_cnt == YEL) begin m_st = 2; m_cnt = 0; end
    end else begin
      m_cnt++;
      if (m_cnt == AR) begin
        m_st = 0; m_cnt = 0; m_done = 1;
        if (pre) begin
          nx = int'(pph);
        end else begin
          nx = 0;
          for (int k = 1; k <= NPH; k++) begin
            if (m_pend[(m_ph + k) % NPH]) begin
              nx = (m_ph + k) % NPH;
              break;
            end
          end
        end
        m_ph = nx;
        np[m_ph] = 1'b0;
      end
    end
    m_pend = np;
  endtask

  initial begin
    int g2, g5, g6, gend, gcnt;
    bit pre_r;
    logic [1:0] pph_r;
    logic [3:0] rq_r;
    bit rst_r;

    rst = 1'b1; req = '0; preempt = 1'b0; preempt_ph = '0;

    // test 2 rows: req[2] pulse right after reset
    g2 = tv.size();
    add(1, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0000, 0);
    add(0, 4'b0100, 0, 0, 0, LAMP_GRN, 4'b0100, 0);
    for (int i = 2; i <= 4; i++)
      add(0, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_YEL, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_YEL, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_RED, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 2, LAMP_GRN, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 2, LAMP_GRN, 4'b0000, 0);

    // test 5 rows: preempt to phase 3 during phase 1 green
    g5 = tv.size();
    add(1, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 0, LAMP_GRN, 4'b0010, 0);
    for (int i = 2; i <= 4; i++)
      add(0, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_YEL, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_YEL, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_RED, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 1, LAMP_GRN, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 1, LAMP_GRN, 4'b0000, 0);
    add(0, 4'b0000, 1, 3, 1, LAMP_YEL, 4'b0000, 0);
    add(0, 4'b0000, 1, 3, 1, LAMP_YEL, 4'b0000, 0);
    add(0, 4'b0001, 1, 3, 1, LAMP_RED, 4'b0001, 0);
    add(0, 4'b0001, 1, 3, 3, LAMP_GRN, 4'b0001, 1);
    for (int i = 14; i <= 16; i++)
      add(0, 4'b0001, 1, 3, 3, LAMP_GRN, 4'b0001, 0);

    // test 6 rows: reset in the middle of yellow
    g6 = tv.size();
    add(1, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0000, 0);
    add(0, 4'b1010, 0, 0, 0, LAMP_GRN, 4'b1010, 0);
    for (int i = 2; i <= 4; i++)
      add(0, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b1010, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_YEL, 4'b1010, 0);
    add(1, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 0, LAMP_GRN, 4'b0000, 0);
    gend = tv.size();

    // test 1: idle after reset
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      check($sformatf("idle_c%0d", c),
            {18'd0, phase_done, active_ph, light},
            {18'd0, 1'b0, 2'd0, exp_light(0, LAMP_GRN)});
      tick();
    end

    // test 2 then test 3 from the phase-2 green it leaves
    run_rows(g2, g5);
    req = 4'b1010;
    tick();
    req = 4'b0000;
    wait_done("rr_first_3", 60, 3);
    wait_done("rr_then_1", 60, 1);

    // test 4: own demand held keeps green to the max
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    gcnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (light[2:0] !== LAMP_GRN) break;
      gcnt++;
      tick();
      req = 4'b0001;
    end
    req = 4'b0000;
    check("max_green_len", 32'(gcnt), 32'd15);
    check("max_green_yel", 32'(light), 32'(exp_light(0, LAMP_YEL)));

    // test 5 and the long preempt hold
    run_rows(g5, g6);
    preempt = 1'b1; preempt_ph = 2'd3; req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("pre_hold%0d", c), {18'd0, active_ph, light},
            {18'd0, 2'd3, exp_light(3, LAMP_GRN)});
    end
    preempt = 1'b0; req = 4'b0000;
    wait_done("pre_release", 40, 0);

    // test 6
    run_rows(g6, gend);

    // random traffic against the model
    rst = 1'b1;
    model_step(1, '0, 0, '0);
    tick();
    rst = 1'b0;
    pre_r = 0; pph_r = '0;
    for (int c = 0; c < 4000; c++) begin
      rq_r = '0;
      for (int b = 0; b < NPH; b++)
        if ($urandom_range(0, 5) == 0) rq_r[b] = 1'b1;
      if (!pre_r && $urandom_range(0, 39) == 0) begin
        pre_r = 1; pph_r = 2'($urandom_range(0, 3));
      end else if (pre_r && $urandom_range(0, 14) == 0) begin
        pre_r = 0;
      end
      rst_r = ($urandom_range(0, 799) == 0);
      rst = rst_r; req = rq_r; preempt = pre_r; preempt_ph = pph_r;
      model_step(rst_r, rq_r, pre_r, pph_r);
      tick();
      check($sformatf("rand_c%0d", c),
            {13'd0, light, active_ph, req_pend, phase_done},
            {13'd0, exp_light(m_ph, st_lamp(m_st)), 2'(m_ph),
             m_pend, m_done});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
